// File: rtl/down_width_conv_if.sv
// Handshake bundle for down_width_conv: wide valid/ready input side, narrow valid/ready output side.
// slave is the converter's view; master is the surrounding environment's view.
interface down_width_conv_if #(
  parameter int DIN_WIDTH  = 32,
  parameter int DOUT_WIDTH = 8
);
  logic [DIN_WIDTH-1:0]    din;
  logic [DIN_WIDTH/8-1:0]  din_strb;
  logic                    din_last;
  logic                    din_valid;
  logic                    din_ready;
  logic [DOUT_WIDTH-1:0]   dout;
  logic [DOUT_WIDTH/8-1:0] dout_strb;
  logic                    dout_last;
  logic                    dout_valid;
  logic                    dout_ready;

  modport slave (
    input  din, din_strb, din_last, din_valid, dout_ready,
    output din_ready, dout, dout_strb, dout_last, dout_valid
  );

  modport master (
    output din, din_strb, din_last, din_valid, dout_ready,
    input  din_ready, dout, dout_strb, dout_last, dout_valid
  );
endinterface

// File: rtl/down_width_conv.sv
// Strobe-aware down width converter: one wide word in, its narrow lanes out lane 0 first.
// Define DOWN_WIDTH_CONV_SKIP_NULL_EN to drop lanes whose strobes are all zero.
module down_width_conv #(
  parameter int DIN_WIDTH  = 32,
  parameter int DOUT_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cen,
  down_width_conv_if.slave bus
);
  localparam int R  = DIN_WIDTH / DOUT_WIDTH;
  localparam int LW = (R > 1) ? $clog2(R) : 1;
  localparam int SB = DOUT_WIDTH / 8;
  localparam int SW = DIN_WIDTH / 8;

  if ((DIN_WIDTH % 8) != 0 || (DOUT_WIDTH % 8) != 0 ||
      DIN_WIDTH <= DOUT_WIDTH || (DIN_WIDTH % DOUT_WIDTH) != 0) begin : g_bad_cfg
    $error("down_width_conv: DIN_WIDTH must be a byte-multiple greater than and divisible by DOUT_WIDTH");
  end

  logic [DIN_WIDTH-1:0]  hold_data;
  logic [SW-1:0]         hold_strb;
  logic                  hold_last;
  logic                  hold_valid;
  logic [LW-1:0]         lane;
  logic [LW-1:0]         first_lane;
  logic [LW-1:0]         next_lane;
  logic                  lane_final;
  logic [DOUT_WIDTH-1:0] lane_data;
  logic [SB-1:0]         lane_strb;
  logic                  slot_free;
  logic                  move;
  logic                  accept;

`ifdef DOWN_WIDTH_CONV_SKIP_NULL_EN
  function automatic logic lane_nz(input logic [SW-1:0] strb, input int k);
    return |strb[k*SB +: SB];
  endfunction

  // An all-null word still emits lane 0 so its last flag reaches the output.
  always_comb begin
    first_lane = '0;
    for (int k = R - 1; k >= 0; k--) begin
      if (lane_nz(bus.din_strb, k)) first_lane = LW'(k);
    end
  end

  always_comb begin
    next_lane  = lane;
    lane_final = 1'b1;
    for (int k = R - 1; k >= 0; k--) begin
      if (k > int'(lane) && lane_nz(hold_strb, k)) begin
        next_lane  = LW'(k);
        lane_final = 1'b0;
      end
    end
  end
`else
  assign first_lane = '0;
  assign next_lane  = lane + LW'(1);
  assign lane_final = (lane == LW'(R - 1));
`endif

  assign lane_data = hold_data[int'(lane)*DOUT_WIDTH +: DOUT_WIDTH];
  assign lane_strb = hold_strb[int'(lane)*SB +: SB];

  assign slot_free     = ~bus.dout_valid | bus.dout_ready;
  assign move          = cen & slot_free & hold_valid;
  // Accepting on the final-lane move lets words stream with no bubble.
  assign bus.din_ready = cen & (~hold_valid | (slot_free & lane_final));
  assign accept        = bus.din_valid & bus.din_ready;

  // Holding stage: wide word payload, only meaningful while hold_valid is set.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_data <= bus.din;
      hold_strb <= bus.din_strb;
      hold_last <= bus.din_last;
    end
  end

  // Output stage and lane sequencing.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.dout       <= '0;
      bus.dout_strb  <= '0;
      bus.dout_last  <= 1'b0;
      bus.dout_valid <= 1'b0;
      hold_valid     <= 1'b0;
      lane           <= '0;
    end else if (cen) begin
      if (move) begin
        bus.dout       <= lane_data;
        bus.dout_strb  <= lane_strb;
        bus.dout_last  <= hold_last & lane_final;
        bus.dout_valid <= 1'b1;
      end else if (slot_free) begin
        bus.dout_valid <= 1'b0;
      end

      if (accept) begin
        hold_valid <= 1'b1;
        lane       <= first_lane;
      end else if (move) begin
        if (lane_final) hold_valid <= 1'b0;
        else            lane       <= next_lane;
      end
    end
  end
endmodule

// File: tb/tb_down_width_conv.sv
// Bench for down_width_conv (32 -> 8): directed vector table, multi-cycle corner sequences,
// and randomized traffic scored against a lane-list model of each accepted word.
module tb_down_width_conv;
  localparam int DW = 32;
  localparam int OW = 8;

  logic clk = 1'b0;
  logic rstn;
  logic cen;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  down_width_conv_if #(.DIN_WIDTH(DW), .DOUT_WIDTH(OW)) bus ();

  down_width_conv #(.DIN_WIDTH(DW), .DOUT_WIDTH(OW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .cen  (cen),
    .bus  (bus)
  );

  typedef struct {
    logic [7:0] d;
    logic       s;
    logic       l;
    int         stamp;
  } beat_t;

  typedef struct {
    logic [31:0] din;
    logic [3:0]  strb;
    logic        last;
    int          n;
    logic [31:0] ed;
    logic [3:0]  es;
    logic [3:0]  el;
  } vec_t;

  beat_t got_q[$];
  beat_t exp_q[$];
  int    acc_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  logic       stall_prev;
  logic [7:0] st_d;
  logic       st_s;
  logic       st_l;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: the list of lanes a word emits, then one beat per listed lane.
  task automatic model_word(input logic [31:0] d, input logic [3:0] s, input logic l);
    int lanes[$];
`ifdef DOWN_WIDTH_CONV_SKIP_NULL_EN
    for (int k = 0; k < 4; k++) if (s[k]) lanes.push_back(k);
    if (lanes.size() == 0) lanes.push_back(0);
`else
    for (int k = 0; k < 4; k++) lanes.push_back(k);
`endif
    for (int i = 0; i < lanes.size(); i++)
      exp_q.push_back('{d[8*lanes[i] +: 8], s[lanes[i]], l && (i == lanes.size() - 1), 0});
  endtask

  task automatic monitor();
    stall_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev)
          chk("stall_hold", {bus.dout_valid, bus.dout, bus.dout_strb, bus.dout_last},
              {1'b1, st_d, st_s, st_l});
        stall_prev = bus.dout_valid && !(bus.dout_ready && cen);
        st_d = bus.dout;
        st_s = bus.dout_strb[0];
        st_l = bus.dout_last;
        if (cen && bus.dout_valid && bus.dout_ready)
          got_q.push_back('{bus.dout, bus.dout_strb[0], bus.dout_last, cyc + 1});
        if (bus.din_valid && bus.din_ready) begin
          acc_q.push_back(cyc + 1);
          model_word(bus.din, bus.din_strb, bus.din_last);
        end
      end
    end
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] s, input logic l);
    int t;
    t = 0;
    bus.din       = d;
    bus.din_strb  = s;
    bus.din_last  = l;
    bus.din_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (bus.din_ready) break;
      t++;
      if (t > 2000) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: din_ready low for %0d cycles, required 1", t);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.din_valid = 1'b0;
  endtask

  task automatic wait_beats(input int target, input string name);
    int t;
    t = 0;
    while (got_q.size() < target && t < 1000) begin
      @(negedge clk);
      t++;
    end
    repeat (6) @(negedge clk);
    chk({name, "_count"}, got_q.size(), target);
    @(posedge clk);
    #1;
  endtask

  task automatic run_tests();
    vec_t tbl[6];
    logic pat[6];
    int   gb, ab, eb;
    logic [7:0] held;
    bit   done;

    // Reset state, with cen low then high.
    rstn = 1'b1; cen = 1'b0; bus.din_valid = 1'b0; bus.dout_ready = 1'b1;
    bus.din = '0; bus.din_strb = '0; bus.din_last = 1'b0;
    #1 rstn = 1'b0;
    #1;
    chk("rst_outputs", {bus.dout_valid, bus.dout, bus.dout_strb, bus.dout_last}, 11'h0);
    chk("rst_ready_cen0", bus.din_ready, 1'b0);
    cen = 1'b1;
    #1;
    chk("rst_ready_cen1", bus.din_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // Directed table: dout_ready held high, one word at a time.
    tbl[0] = '{32'h44332211, 4'hF, 1'b1, 4, 32'h44332211, 4'hF, 4'h8};
    tbl[4] = '{32'hDEADBEEF, 4'hF, 1'b0, 4, 32'hDEADBEEF, 4'hF, 4'h0};
`ifdef DOWN_WIDTH_CONV_SKIP_NULL_EN
    tbl[1] = '{32'h00002211, 4'h3, 1'b1, 2, 32'h00002211, 4'h3, 4'h2};
    tbl[2] = '{32'h00330011, 4'h5, 1'b1, 2, 32'h00003311, 4'h3, 4'h2};
    tbl[3] = '{32'hAABBCCDD, 4'h0, 1'b1, 1, 32'h000000DD, 4'h0, 4'h1};
    tbl[5] = '{32'h9A000000, 4'h8, 1'b1, 1, 32'h0000009A, 4'h1, 4'h1};
`else
    tbl[1] = '{32'h00002211, 4'h3, 1'b1, 4, 32'h00002211, 4'h3, 4'h8};
    tbl[2] = '{32'h00330011, 4'h5, 1'b1, 4, 32'h00330011, 4'h5, 4'h8};
    tbl[3] = '{32'hAABBCCDD, 4'h0, 1'b1, 4, 32'hAABBCCDD, 4'h0, 4'h8};
    tbl[5] = '{32'h9A000000, 4'h8, 1'b1, 4, 32'h9A000000, 4'h8, 4'h8};
`endif
    for (int r = 0; r < 6; r++) begin
      gb = got_q.size();
      send(tbl[r].din, tbl[r].strb, tbl[r].last);
      wait_beats(gb + tbl[r].n, $sformatf("tbl%0d", r));
      for (int i = 0; i < tbl[r].n && gb + i < got_q.size(); i++)
        chk($sformatf("tbl%0d_beat%0d", r, i),
            {got_q[gb+i].d, got_q[gb+i].s, got_q[gb+i].l},
            {tbl[r].ed[8*i +: 8], tbl[r].es[i], tbl[r].el[i]});
    end

    // Back-to-back full words: latency, 8 consecutive beats, accept on final-lane move.
    gb = got_q.size();
    ab = acc_q.size();
    send(32'h44332211, 4'hF, 1'b1);
    send(32'h88776655, 4'hF, 1'b1);
    wait_beats(gb + 8, "b2b");
    if (got_q.size() >= gb + 8 && acc_q.size() >= ab + 2) begin
      chk("b2b_latency", got_q[gb].stamp, acc_q[ab] + 2);
      chk("b2b_accept2", acc_q[ab+1], got_q[gb+2].stamp);
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("b2b_beat%0d", i), {got_q[gb+i].d, got_q[gb+i].s, got_q[gb+i].l},
            {8'h11 * 8'(i + 1), 1'b1, (i == 3) || (i == 7)});
        chk($sformatf("b2b_stamp%0d", i), got_q[gb+i].stamp, got_q[gb].stamp + i);
      end
    end

    // Backpressure pattern 1,0,0,1,0,1 on dout_ready.
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    gb = got_q.size();
    ab = acc_q.size();
    fork
      begin
        send(32'h44332211, 4'hF, 1'b1);
        send(32'h88776655, 4'hF, 1'b0);
      end
      for (int i = 0; i < 40; i++) begin
        bus.dout_ready = pat[i % 6];
        @(posedge clk);
        #1;
      end
    join
    bus.dout_ready = 1'b1;
    wait_beats(gb + 8, "bp");
    if (got_q.size() >= gb + 8 && acc_q.size() >= ab + 2) begin
      chk("bp_accept2", acc_q[ab+1], got_q[gb+2].stamp);
      for (int i = 0; i < 8; i++)
        chk($sformatf("bp_beat%0d", i), {got_q[gb+i].d, got_q[gb+i].l},
            {8'h11 * 8'(i + 1), i == 3});
    end

    // cen low for 3 cycles after the first beat.
    gb = got_q.size();
    send(32'h44332211, 4'hF, 1'b1);
    for (int t = 0; t < 50 && got_q.size() < gb + 1; t++) @(negedge clk);
    @(posedge clk);
    #1 cen = 1'b0;
    held = bus.dout;
    chk("cen_held_lane1", held, 8'h22);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("cen_freeze%0d", i), {bus.dout_valid, bus.dout, bus.din_ready}, {1'b1, held, 1'b0});
    end
    @(posedge clk);
    #1 cen = 1'b1;
    wait_beats(gb + 4, "cen");
    if (got_q.size() >= gb + 4)
      for (int i = 0; i < 4; i++)
        chk($sformatf("cen_beat%0d", i), got_q[gb+i].d, 8'h11 * 8'(i + 1));

    // Reset pulsed after the second beat.
    gb = got_q.size();
    send(32'h44332211, 4'hF, 1'b1);
    for (int t = 0; t < 50 && got_q.size() < gb + 2; t++) @(negedge clk);
    @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    chk("midrst_outputs", {bus.dout_valid, bus.dout, bus.dout_strb, bus.dout_last}, 11'h0);
    chk("midrst_ready", bus.din_ready, 1'b1);
    @(posedge clk);
    #1 rstn = 1'b1;
    wait_beats(gb + 2, "midrst_discard");
    gb = got_q.size();
    send(32'h44332211, 4'hF, 1'b1);
    wait_beats(gb + 4, "postrst");
    if (got_q.size() >= gb + 4)
      for (int i = 0; i < 4; i++)
        chk($sformatf("postrst_beat%0d", i), {got_q[gb+i].d, got_q[gb+i].l},
            {8'h11 * 8'(i + 1), i == 3});

    // Randomized traffic with random dout_ready and cen against the model.
    gb = got_q.size();
    eb = exp_q.size();
    done = 1'b0;
    fork
      begin
        for (int w = 0; w < 300; w++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send($urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
        done = 1'b1;
      end
      while (!done) begin
        bus.dout_ready = ($urandom_range(0, 9) < 7);
        cen            = ($urandom_range(0, 9) < 9);
        @(posedge clk);
        #1;
      end
    join
    bus.dout_ready = 1'b1;
    cen = 1'b1;
    wait_beats(gb + (exp_q.size() - eb), "rand");
    for (int i = 0; i < exp_q.size() - eb && gb + i < got_q.size(); i++)
      chk($sformatf("rand_beat%0d", i), {got_q[gb+i].d, got_q[gb+i].s, got_q[gb+i].l},
          {exp_q[eb+i].d, exp_q[eb+i].s, exp_q[eb+i].l});
  endtask

  initial begin
    fork
      monitor();
      run_tests();
      begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required test completion");
        $fatal(1, "watchdog");
      end
    join_any
    disable fork;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
